carregador_instrucoes: RTL

Program loader that writes the instruction RAM. It accepts a byte stream through a valid/ready handshake and packs every 4 bytes into one 32-bit instruction. Each packed instruction is written into the selected 1000-word program slot: slot 0 is the context-switch routine, slot 1 is the OS, slots 2-6 are user programs. The loader sits between the host/UART byte source and the instruction RAM write port, so programs can be loaded at run time instead of from preloaded files.

---
 rtl/carregador_instrucoes_pkg.sv | 27 ++
 rtl/empacotador_bytes.sv | 39 +++
 rtl/carregador_instrucoes.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/carregador_instrucoes_pkg.sv
// Slot map and loader state encoding shared by the loader, the processor and the OS code.
package carregador_instrucoes_pkg;

  localparam int unsigned SLOT_SIZE = 32'd1000;
  localparam int unsigned NUM_SLOTS = 32'd7;

  localparam logic [2:0] SLOT_TROCA_CONTEXTO = 3'd0;
  localparam logic [2:0] SLOT_SO             = 3'd1;
  localparam logic [2:0] SLOT_PROG1          = 3'd2;
  localparam logic [2:0] SLOT_PROG2          = 3'd3;
  localparam logic [2:0] SLOT_PROG3          = 3'd4;
  localparam logic [2:0] SLOT_PROG4          = 3'd5;
  localparam logic [2:0] SLOT_PROG5          = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEBE  = 2'd1,
    ESCREVE = 2'd2,
    FIM     = 2'd3
  } estado_t;

  // First word address of a slot in instruction RAM.
  function automatic logic [31:0] base_do_slot(input logic [2:0] slot, input int unsigned tamanho);
    return 32'(slot) * tamanho;
  endfunction

endpackage

// File: rtl/empacotador_bytes.sv
// Byte-to-word shift register: bytes enter MSB-first, word_pronto flags the byte
// that completes a word and palavra carries that completed word in the same cycle.
module empacotador_bytes #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  limpa,
  input  logic                  aceita,
  input  logic [7:0]            byte_in,
  output logic                  word_pronto,
  output logic [DATA_WIDTH-1:0] palavra
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int CONT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CONT_W-1:0] ULTIMO = CONT_W'(BYTES - 1);

  logic [CONT_W-1:0]     contagem_r;
  logic [DATA_WIDTH-1:0] deslocamento_r;

  assign word_pronto = aceita && (contagem_r == ULTIMO);
  assign palavra     = (deslocamento_r << 8) | DATA_WIDTH'(byte_in);

  // Shift accepted bytes in and count them modulo the word size.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      contagem_r     <= '0;
      deslocamento_r <= '0;
    end else if (limpa) begin
      contagem_r     <= '0;
      deslocamento_r <= '0;
    end else if (aceita) begin
      deslocamento_r <= palavra;
      contagem_r     <= word_pronto ? '0 : contagem_r + CONT_W'(1);
    end
  end

endmodule

// File: rtl/carregador_instrucoes.sv
// Program loader: packs a valid/ready byte stream into instruction words and writes
// them into the selected program slot of the instruction RAM.
import carregador_instrucoes_pkg::*;

module carregador_instrucoes #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned SLOT_SIZE  = 32'd1000,
  parameter int unsigned NUM_SLOTS  = 32'd7
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            slot,
  input  logic [9:0]            num_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] endereco_escrita,
  output logic [DATA_WIDTH-1:0] dado_escrita,
  output logic                  busy,
  output logic                  done,
  output logic                  erro,
  input  logic                  abort
);

  estado_t               estado_r;
  logic                  pronto_r;
  logic                  we_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  erro_r;
  logic [ADDR_WIDTH-1:0] endereco_r;
  logic [DATA_WIDTH-1:0] dado_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [9:0]            total_r;
  logic [9:0]            contagem_r;

  logic                  parametros_validos_s;
  logic                  aceita_s;
  logic                  limpa_s;
  logic                  word_pronto_s;
  logic [DATA_WIDTH-1:0] palavra_s;
  logic [9:0]            proxima_contagem_s;

  assign parametros_validos_s = (32'(slot) < NUM_SLOTS) && (num_words != 10'd0)
                                && (32'(num_words) <= SLOT_SIZE);
  // abort must win over a same-cycle handshake, so ready is masked combinationally.
  assign byte_ready         = pronto_r & ~abort;
  assign aceita_s           = byte_valid & byte_ready;
  assign limpa_s            = (estado_r != RECEBE) || abort;
  assign proxima_contagem_s = contagem_r + 10'd1;

  empacotador_bytes #(.DATA_WIDTH(DATA_WIDTH)) u_empacotador (
    .clock       (clock),
    .reset_n     (reset_n),
    .limpa       (limpa_s),
    .aceita      (aceita_s),
    .byte_in     (byte_data),
    .word_pronto (word_pronto_s),
    .palavra     (palavra_s)
  );

  // Load sequencing with all handshake, write-port and status outputs registered.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_r   <= IDLE;
      pronto_r   <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      erro_r     <= 1'b0;
      endereco_r <= '0;
      dado_r     <= '0;
      base_r     <= '0;
      total_r    <= 10'd0;
      contagem_r <= 10'd0;
    end else begin
      we_r   <= 1'b0;
      done_r <= 1'b0;
      case (estado_r)
        IDLE: begin
          if (start && parametros_validos_s) begin
            base_r     <= ADDR_WIDTH'(base_do_slot(slot, SLOT_SIZE));
            total_r    <= num_words;
            contagem_r <= 10'd0;
            erro_r     <= 1'b0;
            busy_r     <= 1'b1;
            pronto_r   <= 1'b1;
            estado_r   <= RECEBE;
          end else if (start) begin
            erro_r <= 1'b1;
          end
        end
        RECEBE: begin
          if (abort) begin
            erro_r   <= 1'b1;
            busy_r   <= 1'b0;
            pronto_r <= 1'b0;
            estado_r <= IDLE;
          end else if (word_pronto_s) begin
            we_r       <= 1'b1;
            endereco_r <= base_r + ADDR_WIDTH'(contagem_r);
            dado_r     <= palavra_s;
            pronto_r   <= 1'b0;
            estado_r   <= ESCREVE;
          end
        end
        ESCREVE: begin
          contagem_r <= proxima_contagem_s;
          if (abort) begin
            erro_r   <= 1'b1;
            busy_r   <= 1'b0;
            estado_r <= IDLE;
          end else if (proxima_contagem_s == total_r) begin
            done_r   <= 1'b1;
            estado_r <= FIM;
          end else begin
            pronto_r <= 1'b1;
            estado_r <= RECEBE;
          end
        end
        FIM: begin
          busy_r   <= 1'b0;
          estado_r <= IDLE;
        end
        default: begin
          busy_r   <= 1'b0;
          pronto_r <= 1'b0;
          estado_r <= IDLE;
        end
      endcase
    end
  end

  assign we               = we_r;
  assign endereco_escrita = endereco_r;
  assign dado_escrita     = dado_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign erro             = erro_r;

endmodule
